// File: rtl/reg_bank_88.sv
// Eight-entry 8-bit working-register bank with 8/16-bit inc/dec and zero/carry flags.
// Ports: clk, rst_n, op[2:0], wsel[2:0], wdata[7:0] in; r0..r7[7:0], zero, carry out.
module reg_bank_88 #(
   parameter logic [7:0] RESET_VAL   = 8'h00,
   parameter bit         PAIR_LITTLE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] op,
   input  logic [2:0] wsel,
   input  logic [7:0] wdata,
   output logic [7:0] r0,
   output logic [7:0] r1,
   output logic [7:0] r2,
   output logic [7:0] r3,
   output logic [7:0] r4,
   output logic [7:0] r5,
   output logic [7:0] r6,
   output logic [7:0] r7,
   output logic       zero,
   output logic       carry
);

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_INC   = 3'b010;
   localparam logic [2:0] OP_DEC   = 3'b011;
   localparam logic [2:0] OP_CLR   = 3'b100;
   localparam logic [2:0] OP_INC16 = 3'b101;
   localparam logic [2:0] OP_DEC16 = 3'b110;

   logic [7:0]  regs     [8];
   logic [7:0]  regs_nxt [8];
   logic        zero_nxt;
   logic        carry_nxt;

   logic [2:0]  hi_idx;
   logic [2:0]  lo_idx;
   logic [7:0]  cur8;
   logic [7:0]  res8;
   logic [15:0] cur16;
   logic [15:0] res16;

   // Byte order inside a pair: little puts the odd register on top.
   assign hi_idx = {wsel[2:1], PAIR_LITTLE};
   assign lo_idx = {wsel[2:1], ~PAIR_LITTLE};

   assign cur8  = regs[wsel];
   assign cur16 = {regs[hi_idx], regs[lo_idx]};

   always_comb begin
      regs_nxt  = regs;
      zero_nxt  = zero;
      carry_nxt = carry;
      res8      = 8'h00;
      res16     = 16'h0000;
      // Plain case with default: unknown op bits fall back to hold.
      case (op)
         OP_LOAD: begin
            regs_nxt[wsel] = wdata;
            zero_nxt       = (wdata == 8'h00);
         end
         OP_INC: begin
            res8           = cur8 + 8'd1;
            regs_nxt[wsel] = res8;
            zero_nxt       = (res8 == 8'h00);
            carry_nxt      = (cur8 == 8'hFF);
         end
         OP_DEC: begin
            res8           = cur8 - 8'd1;
            regs_nxt[wsel] = res8;
            zero_nxt       = (res8 == 8'h00);
            carry_nxt      = (cur8 == 8'h00);
         end
         OP_CLR: begin
            regs_nxt[wsel] = 8'h00;
            zero_nxt       = 1'b1;
            carry_nxt      = 1'b0;
         end
         OP_INC16: begin
            res16            = cur16 + 16'd1;
            regs_nxt[hi_idx] = res16[15:8];
            regs_nxt[lo_idx] = res16[7:0];
            zero_nxt         = (res16 == 16'h0000);
            carry_nxt        = (cur16 == 16'hFFFF);
         end
         OP_DEC16: begin
            res16            = cur16 - 16'd1;
            regs_nxt[hi_idx] = res16[15:8];
            regs_nxt[lo_idx] = res16[7:0];
            zero_nxt         = (res16 == 16'h0000);
            carry_nxt        = (cur16 == 16'h0000);
         end
         OP_NOP: begin
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= RESET_VAL;
         end
         zero  <= (RESET_VAL == 8'h00);
         carry <= 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= regs_nxt[i];
         end
         zero  <= zero_nxt;
         carry <= carry_nxt;
      end
   end

   assign r0 = regs[0];
   assign r1 = regs[1];
   assign r2 = regs[2];
   assign r3 = regs[3];
   assign r4 = regs[4];
   assign r5 = regs[5];
   assign r6 = regs[6];
   assign r7 = regs[7];

endmodule

// File: tb/tb_reg_bank_88.sv
// Scoreboard bench for reg_bank_88: directed vectors, queued expectations.
// Monitor pops one expectation per clock while the queue holds entries.
module tb_reg_bank_88;

   logic       clk;
   logic       rst_n;
   logic [2:0] op;
   logic [2:0] wsel;
   logic [7:0] wdata;
   logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic       zero;
   logic       carry;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [63:0] r;
      logic        z;
      logic        c;
      string       nm;
   } exp_t;

   exp_t       q[$];
   logic [7:0] e [8];
   logic       ez;
   logic       ec;

   localparam logic [2:0] NOP   = 3'b000;
   localparam logic [2:0] LOAD  = 3'b001;
   localparam logic [2:0] INC   = 3'b010;
   localparam logic [2:0] DEC   = 3'b011;
   localparam logic [2:0] CLR   = 3'b100;
   localparam logic [2:0] INC16 = 3'b101;
   localparam logic [2:0] DEC16 = 3'b110;
   localparam logic [2:0] RSV   = 3'b111;

   reg_bank_88 #(.RESET_VAL(8'h00), .PAIR_LITTLE(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .op    (op),
      .wsel  (wsel),
      .wdata (wdata),
      .r0    (r0),
      .r1    (r1),
      .r2    (r2),
      .r3    (r3),
      .r4    (r4),
      .r5    (r5),
      .r6    (r6),
      .r7    (r7),
      .zero  (zero),
      .carry (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pack_exp();
      return {e[7], e[6], e[5], e[4], e[3], e[2], e[1], e[0]};
   endfunction

   function automatic logic [63:0] pack_dut();
      return {r7, r6, r5, r4, r3, r2, r1, r0};
   endfunction

   task automatic chk64(input string nm, input logic [63:0] got,
                        input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, want);
      end
   endtask

   task automatic chk1(input string nm, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", nm, got, want);
      end
   endtask

   task automatic reset_exp();
      for (int i = 0; i < 8; i++) e[i] = 8'h00;
      ez = 1'b1;
      ec = 1'b0;
   endtask

   task automatic issue(input logic [2:0] o, input logic [2:0] s,
                        input logic [7:0] d, input string nm);
      exp_t x;
      @(negedge clk);
      op    = o;
      wsel  = s;
      wdata = d;
      x.r   = pack_exp();
      x.z   = ez;
      x.c   = ec;
      x.nm  = nm;
      q.push_back(x);
   endtask

   // 8-bit op with hand-computed result for the target register.
   task automatic v8(input logic [2:0] o, input logic [2:0] s,
                     input logic [7:0] d, input logic [7:0] val,
                     input logic z, input logic c, input string nm);
      e[s] = val;
      ez   = z;
      ec   = c;
      issue(o, s, d, nm);
   endtask

   // 16-bit op on pair s[2:1]; hi is the odd register.
   task automatic v16(input logic [2:0] o, input logic [2:0] s,
                      input logic [7:0] hi, input logic [7:0] lo,
                      input logic z, input logic c, input string nm);
      e[{s[2:1], 1'b1}] = hi;
      e[{s[2:1], 1'b0}] = lo;
      ez = z;
      ec = c;
      issue(o, s, 8'h00, nm);
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (rst_n && q.size() > 0) begin
         x = q.pop_front();
         chk64({x.nm, ".regs"}, pack_dut(), x.r);
         chk1({x.nm, ".zero"}, zero, x.z);
         chk1({x.nm, ".carry"}, carry, x.c);
      end
   end

   initial begin
      rst_n = 1'b1;
      op    = NOP;
      wsel  = 3'd0;
      wdata = 8'h00;
      reset_exp();

      // Asynchronous reset asserted mid-cycle.
      #3 rst_n = 1'b0;
      #1;
      chk64("rst.regs", pack_dut(), 64'h0);
      chk1("rst.zero", zero, 1'b1);
      chk1("rst.carry", carry, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      issue(NOP, 3'd0, 8'h55, "nop_hold");

      v8(LOAD, 3'd3, 8'hFE, 8'hFE, 1'b0, 1'b0, "load_r3");
      v8(INC,  3'd3, 8'h00, 8'hFF, 1'b0, 1'b0, "inc_r3_ff");
      v8(INC,  3'd3, 8'h00, 8'h00, 1'b1, 1'b1, "inc_r3_wrap");

      v8(CLR,  3'd5, 8'h77, 8'h00, 1'b1, 1'b0, "clr_r5");
      v8(DEC,  3'd5, 8'h00, 8'hFF, 1'b0, 1'b1, "dec_r5_borrow");
      v8(LOAD, 3'd5, 8'h00, 8'h00, 1'b1, 1'b1, "load_r5_zero");

      v8(LOAD, 3'd7, 8'h12, 8'h12, 1'b0, 1'b1, "load_r7");
      v8(LOAD, 3'd6, 8'hFF, 8'hFF, 1'b0, 1'b1, "load_r6");
      v16(INC16, 3'b110, 8'h13, 8'h00, 1'b0, 1'b0, "inc16_prop");
      v8(LOAD, 3'd7, 8'hFF, 8'hFF, 1'b0, 1'b0, "load_r7_ff");
      v8(LOAD, 3'd6, 8'hFF, 8'hFF, 1'b0, 1'b0, "load_r6_ff");
      v16(INC16, 3'b110, 8'h00, 8'h00, 1'b1, 1'b1, "inc16_wrap");

      v8(LOAD, 3'd1, 8'h01, 8'h01, 1'b0, 1'b1, "load_r1");
      v8(CLR,  3'd0, 8'h00, 8'h00, 1'b1, 1'b0, "clr_r0");
      v16(DEC16, 3'b000, 8'h00, 8'hFF, 1'b0, 1'b0, "dec16_prop");
      v8(CLR,  3'd0, 8'h00, 8'h00, 1'b1, 1'b0, "clr_r0_b");
      v16(DEC16, 3'b001, 8'hFF, 8'hFF, 1'b0, 1'b1, "dec16_borrow");

      v8(DEC,  3'd4, 8'h00, 8'hFF, 1'b0, 1'b1, "dec_r4");
      v8(INC,  3'd4, 8'h00, 8'h00, 1'b1, 1'b1, "inc_r4_wrap");
      issue(RSV, 3'd2, 8'hAA, "rsv_hold");
      issue(3'bxxx, 3'd2, 8'hAA, "xop_hold");

      v8(INC, 3'd2, 8'h00, 8'h01, 1'b0, 1'b0, "inc_r2_a");
      v8(INC, 3'd2, 8'h00, 8'h02, 1'b0, 1'b0, "inc_r2_b");

      // Reset between edges while another INC is pending.
      @(negedge clk);
      op   = INC;
      wsel = 3'd2;
      #2 rst_n = 1'b0;
      #1;
      reset_exp();
      chk64("midrst.regs", pack_dut(), 64'h0);
      chk1("midrst.zero", zero, 1'b1);
      chk1("midrst.carry", carry, 1'b0);
      @(negedge clk);
      op    = NOP;
      rst_n = 1'b1;

      v8(INC, 3'd2, 8'h00, 8'h01, 1'b0, 1'b0, "post_rst_inc");
      issue(RSV, 3'd2, 8'h00, "post_rst_rsv");

      @(negedge clk);
      op = NOP;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain pending=%0d exp=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_bank_88.md
Name: reg_bank_88

Overview:
- Eight-entry, 8-bit working-register bank that sits directly upstream of the 8-way, 8-bit bus source mux.
- Outputs r0..r7 wire straight to the mux data inputs a..h.
- Performs one register operation per clock: load, clear, 8-bit increment/decrement, or 16-bit pair increment/decrement for pointer use.
- Produces registered zero/carry flags for the sequencer.

Parameters:
- RESET_VAL, 8'h00, value loaded into every register on reset.
- PAIR_LITTLE, 1, 1 = pair k is {r(2k+1), r(2k)} (high, low); 0 = {r(2k), r(2k+1)}.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  3  operation: 000 NOP, 001 LOAD, 010 INC, 011 DEC, 100 CLR, 101 INC16, 110 DEC16, 111 NOP (reserved).
- wsel  in  3  target register for 8-bit ops; wsel[2:1] selects the pair for 16-bit ops, wsel[0] ignored.
- wdata  in  8  LOAD data.
- r0..r7  out  8 each  current register contents; feed mux inputs a..h.
- zero  out  1  registered zero flag.
- carry  out  1  registered carry/borrow flag.

Behaviour:
- Reset: while rst_n=0, asynchronously set all r0..r7 to RESET_VAL, zero=1 if RESET_VAL==0 else 0, carry=0. Reset asserted mid-operation overrides that cycle's op with no partial update. The first op is accepted on the first rising edge with rst_n=1.
- All updates occur on the rising clk edge. Results are visible on r* one cycle after op is presented (latency 1). Outputs are driven directly from flops with no combinational path from op/wdata/wsel to r*.
- Exactly one op per cycle. Only the addressed register(s) change; all others hold.
- LOAD: r[wsel] <= wdata. zero <= (wdata==0). carry holds.
- CLR: r[wsel] <= 0. zero <= 1. carry <= 0.
- INC: r[wsel] <= r[wsel]+1, mod 256. carry <= 1 only when old value was 8'hFF (wrap to 00). zero <= (result==0).
- DEC: r[wsel] <= r[wsel]-1, mod 256. carry <= 1 only when old value was 8'h00 (wrap to FF, borrow). zero <= (result==0).
- INC16/DEC16: operate on the 16-bit pair selected by wsel[2:1], ordered per PAIR_LITTLE. Apply ±1 mod 65536 and update both bytes in the same edge. carry <= 1 on FFFF->0000 (INC16) or 0000->FFFF (DEC16). zero <= (16-bit result==0). Low-byte wrap propagates to the high byte; no intermediate state is ever visible.
- NOP and 111: all registers and flags hold.
- An op input containing X/Z bits is treated as NOP in simulation, using explicit case default; registers must not go X.
- Flags reflect only the most recent non-NOP op. They are not recomputed when an unrelated register changes, because no other writer exists.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with RESET_VAL=00 -> immediately r0..r7=00, zero=1, carry=0. Release, then NOP -> all hold.
- LOAD then INC wrap: LOAD r3=FE; INC r3; INC r3 -> r3=FF (zero=0, carry=0), then r3=00 (zero=1, carry=1). All other registers unchanged.
- DEC borrow: CLR r5; DEC r5 -> r5=FF, carry=1, zero=0. A subsequent LOAD r5=00 -> zero=1, carry stays 1.
- INC16 propagation: with PAIR_LITTLE=1, LOAD r7=12, LOAD r6=FF; INC16 wsel=110 -> r7=13, r6=00, carry=0, zero=0, both bytes changing on the same edge. Repeat from r7=FF, r6=FF -> 0000, carry=1, zero=1.
- DEC16 borrow: pair 0 = 0100 (r1=01, r0=00); DEC16 wsel=000 -> r1=00, r0=FF, carry=0. Then pair 0 = 0000 -> FFFF, carry=1.
- Reset mid-stream: issue back-to-back INCs on r2 and assert rst_n=0 between edges -> r2 returns to RESET_VAL asynchronously. The first post-reset INC yields RESET_VAL+1; reserved op 111 causes no change.
